// File: rtl/p18_field_arbiter_if.sv
// Single-port playfield row-memory bus: the arbiter drives it, the RAM answers
// with read data one cycle after an enabled read.
interface p18_field_arbiter_if #(
  parameter int AW    = 5,
  parameter int WIDTH = 13
);
  logic             mem_en;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport master (output mem_en, mem_we, mem_addr, mem_wdata, input mem_rdata);
  modport slave  (input mem_en, mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/p18_field_arbiter.sv
// Playfield memory arbiter: display reads beat the shift-up/insert engine, which
// beats game-logic access; SPI garbage lines queue in a small FIFO.
//
// state | meaning
// IDLE  | no sequence; game may access memory when the FIFO is empty
// CHK   | read row 0 (overflow probe), set r = 1
// RD    | read row r; first RD also judges row 0 for overflow
// WR    | write captured row r into row r-1, advance r or finish
// INS   | write FIFO head into the bottom row and pop
module p18_field_arbiter #(
  parameter int ROWS  = 20,
  parameter int WIDTH = 13,
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start,
  input  logic             spi_write,
  input  logic [WIDTH-1:0] spi_line,
  output logic             line_dropped,
  input  logic             disp_req,
  input  logic [AW-1:0]    disp_row,
  output logic             disp_valid,
  output logic [WIDTH-1:0] disp_data,
  input  logic             game_req,
  input  logic             game_we,
  input  logic [AW-1:0]    game_row,
  input  logic [WIDTH-1:0] game_wdata,
  output logic             game_ack,
  output logic             game_rvalid,
  output logic [WIDTH-1:0] game_rdata,
  output logic             field_overflow,
  output logic             busy,
  p18_field_arbiter_if.master mem
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CHK  = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] INS  = 3'd4;
  localparam logic [AW-1:0] LAST = AW'(ROWS - 1);

  logic [2:0]       state;
  logic [AW-1:0]    r;
  logic [WIDTH-1:0] fifo_q [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic [WIDTH-1:0] hold;
  logic             hold_valid, rd_pending;
  logic             eng_go, fifo_empty, fifo_full, push, pop;
  logic [WIDTH-1:0] rd_src;
  logic             en_c, we_c;
  logic [AW-1:0]    addr_c;
  logic [WIDTH-1:0] wdata_c;

  // eng_go: the engine owns the memory this cycle (not stalled, not aborted)
  assign eng_go       = nRst & ~disp_req & ~start & (state != IDLE);
  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == (PW+1)'(DEPTH));
  assign pop          = eng_go & (state == INS);
  assign push         = nRst & ~start & spi_write & (~fifo_full | pop);
  assign line_dropped = nRst & ~start & spi_write & fifo_full & ~pop;

  // Read data survives a display stall only through the hold register
  assign rd_src         = hold_valid ? hold : mem.mem_rdata;
  assign field_overflow = eng_go & (state == RD) & (r == AW'(1)) & (rd_src != '0);
  assign busy           = (state != IDLE) | ~fifo_empty;
  assign disp_data      = mem.mem_rdata;
  assign game_rdata     = mem.mem_rdata;

  assign mem.mem_en    = en_c;
  assign mem.mem_we    = we_c;
  assign mem.mem_addr  = addr_c;
  assign mem.mem_wdata = wdata_c;

  always_comb begin
    en_c     = 1'b0;
    we_c     = 1'b0;
    addr_c   = '0;
    wdata_c  = '0;
    game_ack = 1'b0;
    if (nRst && disp_req) begin
      en_c   = 1'b1;
      addr_c = disp_row;
    end else if (nRst) begin
      if (state == IDLE) begin
        if (game_req && fifo_empty) begin
          game_ack = 1'b1;
          en_c     = 1'b1;
          we_c     = game_we;
          addr_c   = game_row;
          wdata_c  = game_wdata;
        end
      end else if (!start) begin
        en_c = 1'b1;
        case (state)
          CHK: addr_c = '0;
          RD:  addr_c = r;
          WR: begin
            we_c    = 1'b1;
            addr_c  = r - AW'(1);
            wdata_c = rd_src;
          end
          INS: begin
            we_c    = 1'b1;
            addr_c  = LAST;
            wdata_c = fifo_q[rd_ptr];
          end
          default: en_c = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state       <= IDLE;
      r           <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      hold        <= '0;
      hold_valid  <= 1'b0;
      rd_pending  <= 1'b0;
      disp_valid  <= 1'b0;
      game_rvalid <= 1'b0;
    end else begin
      disp_valid  <= disp_req;
      game_rvalid <= game_ack & ~game_we;
      rd_pending  <= eng_go & ((state == CHK) | (state == RD));
      if (start) begin
        state      <= IDLE;
        r          <= '0;
        hold_valid <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
      end else begin
        if (rd_pending && disp_req) begin
          hold       <= mem.mem_rdata;
          hold_valid <= 1'b1;
        end else if (eng_go) begin
          hold_valid <= 1'b0;
        end
        if (push) begin
          fifo_q[wr_ptr] <= spi_line;
          wr_ptr         <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop) count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
        case (state)
          IDLE: if (!fifo_empty) state <= CHK;
          CHK: if (eng_go) begin
            r     <= AW'(1);
            state <= RD;
          end
          RD: if (eng_go) state <= WR;
          WR: if (eng_go) begin
            if (r == LAST) state <= INS;
            else begin
              r     <= r + 1'b1;
              state <= RD;
            end
          end
          INS: if (eng_go) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_p18_field_arbiter.sv
// Directed + randomized bench for p18_field_arbiter with a RAM model and a
// row-list reference of the playfield.
module tb_p18_field_arbiter;
  localparam int ROWS  = 20;
  localparam int WIDTH = 13;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             nRst = 1'b0;
  logic             start = 1'b0;
  logic             spi_write = 1'b0;
  logic [WIDTH-1:0] spi_line = '0;
  logic             line_dropped;
  logic             disp_req = 1'b0;
  logic [AW-1:0]    disp_row = '0;
  logic             disp_valid;
  logic [WIDTH-1:0] disp_data;
  logic             game_req = 1'b0;
  logic             game_we = 1'b0;
  logic [AW-1:0]    game_row = '0;
  logic [WIDTH-1:0] game_wdata = '0;
  logic             game_ack;
  logic             game_rvalid;
  logic [WIDTH-1:0] game_rdata;
  logic             field_overflow;
  logic             busy;

  always #5 clk = ~clk;

  p18_field_arbiter_if #(.AW(AW), .WIDTH(WIDTH)) bus ();

  p18_field_arbiter #(.ROWS(ROWS), .WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .nRst(nRst), .start(start),
    .spi_write(spi_write), .spi_line(spi_line), .line_dropped(line_dropped),
    .disp_req(disp_req), .disp_row(disp_row), .disp_valid(disp_valid), .disp_data(disp_data),
    .game_req(game_req), .game_we(game_we), .game_row(game_row), .game_wdata(game_wdata),
    .game_ack(game_ack), .game_rvalid(game_rvalid), .game_rdata(game_rdata),
    .field_overflow(field_overflow), .busy(busy), .mem(bus)
  );

  logic [WIDTH-1:0] mem_arr [32];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= mem_arr[bus.mem_addr];
    end
  end

  int n_cmp = 0, n_err = 0;
  int fld [ROWS];
  int exp_ovf = 0, ovf_cnt = 0, drop_cnt = 0, wr_cnt = 0, cyc_n = 0, ovf_cyc = -1;
  logic disp_prev = 1'b0, rd_prev = 1'b0;
  logic [WIDTH-1:0] disp_exp = '0, rd_exp = '0;
  logic busy_s = 1'b0, ack_s = 1'b0, drop_s = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the inputs currently driven; samples outputs mid-cycle
  task automatic tick();
    #1;
    chk("disp_valid", disp_valid, disp_prev);
    if (disp_prev) chk("disp_data", disp_data, disp_exp);
    chk("game_rvalid", game_rvalid, rd_prev);
    if (rd_prev) chk("game_rdata", game_rdata, rd_exp);
    if (game_req) chk("game_ack", game_ack, !disp_req && !busy);
    disp_prev = disp_req;
    disp_exp  = mem_arr[disp_row];
    rd_prev   = game_ack && !game_we;
    rd_exp    = mem_arr[game_row];
    busy_s = busy;
    ack_s  = game_ack;
    drop_s = line_dropped;
    if (field_overflow) begin ovf_cnt++; ovf_cyc = cyc_n; end
    if (line_dropped) drop_cnt++;
    if (bus.mem_en && bus.mem_we) wr_cnt++;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic spi_push(input logic [WIDTH-1:0] line, output logic dropped);
    spi_write = 1'b1;
    spi_line  = line;
    tick();
    dropped   = drop_s;
    spi_write = 1'b0;
  endtask

  task automatic game_access(input logic we, input int row, input int val, output int ack_cyc);
    logic ok;
    ok = 1'b0;
    ack_cyc = -1;
    game_req = 1'b1; game_we = we; game_row = AW'(row); game_wdata = WIDTH'(val);
    for (int i = 0; i < 300; i++) begin
      ack_cyc = cyc_n;
      tick();
      if (ack_s) begin ok = 1'b1; break; end
    end
    game_req = 1'b0; game_we = 1'b0;
    chk("game_ack_timeout", ok, 1'b1);
  endtask

  task automatic wait_idle(input logic rnd, output int lat);
    logic done;
    done = 1'b0;
    lat = 0;
    for (int i = 0; i < 600; i++) begin
      if (rnd) begin
        disp_req = ($urandom_range(0, 3) == 0);
        disp_row = AW'($urandom_range(0, ROWS - 1));
      end
      tick();
      if (!busy_s) begin done = 1'b1; break; end
      lat++;
    end
    disp_req = 1'b0;
    chk("idle_timeout", done, 1'b1);
  endtask

  // Reference: the whole field moves up a row, new line enters at the bottom
  task automatic model_shift(input int line);
    if (fld[0] != 0) exp_ovf++;
    for (int i = 0; i < ROWS - 1; i++) fld[i] = fld[i + 1];
    fld[ROWS - 1] = line;
  endtask

  task automatic check_field(input string tag);
    for (int i = 0; i < ROWS; i++)
      chk($sformatf("%s_row%0d", tag, i), 32'(mem_arr[i]), fld[i]);
    chk($sformatf("%s_ovf", tag), ovf_cnt, exp_ovf);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, c0, d0, w0, acyc, off, val;
    logic dr;
    logic [WIDTH-1:0] ln;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_en", bus.mem_en, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_disp_valid", disp_valid, 1'b0);
    chk("rst_game_ack", game_ack, 1'b0);
    chk("rst_game_rvalid", game_rvalid, 1'b0);
    chk("rst_line_dropped", line_dropped, 1'b0);
    chk("rst_field_overflow", field_overflow, 1'b0);
    nRst = 1'b1;

    // 1: preload row index, insert 0x1ABC
    for (int i = 0; i < ROWS; i++) begin game_access(1'b1, i, i, acyc); fld[i] = i; end
    game_access(1'b0, 7, 0, acyc);
    chk("t1_rd_rvalid", game_rvalid, 1'b1);
    chk("t1_rd_data", game_rdata, 32'd7);
    spi_push(13'h1ABC, dr);
    chk("t1_drop", dr, 1'b0);
    wait_idle(1'b0, lat);
    chk("t1_latency", lat, 2 * ROWS + 1);
    model_shift(13'h1ABC);
    check_field("t1");

    // 2: row 0 non-zero -> exactly one overflow pulse, right after the CHK read
    game_access(1'b1, 0, 1, acyc);
    fld[0] = 1;
    d0 = ovf_cnt;
    c0 = cyc_n;
    spi_push(WIDTH'($urandom_range(1, 8191)), dr);
    ln = spi_line;
    wait_idle(1'b0, lat);
    chk("t2_ovf_once", ovf_cnt - d0, 1);
    chk("t2_ovf_cycle", ovf_cyc, c0 + 3);
    model_shift(int'(ln));
    check_field("t2");

    // 3: 10-cycle display burst inside a sequence (after CHK, on a WR, random)
    for (int k = 0; k < 3; k++) begin
      off = (k == 0) ? 3 : (k == 1) ? 16 : $urandom_range(4, 30);
      ln = WIDTH'($urandom);
      spi_push(ln, dr);
      repeat (off - 1) tick();
      disp_req = 1'b1;
      for (int j = 0; j < 10; j++) begin
        disp_row = AW'($urandom_range(0, ROWS - 1));
        tick();
      end
      disp_req = 1'b0;
      wait_idle(1'b0, lat);
      chk("t3_latency", lat + off + 9, 2 * ROWS + 11);
      model_shift(int'(ln));
      check_field("t3");
    end

    // 4: six back-to-back writes, FIFO holds four
    d0 = drop_cnt;
    begin
      logic [WIDTH-1:0] lines [6];
      for (int i = 0; i < 6; i++) begin
        lines[i] = WIDTH'($urandom_range(1, 8191));
        spi_push(lines[i], dr);
        chk("t4_drop", dr, (i >= 4));
      end
      wait_idle(1'b0, lat);
      for (int i = 0; i < 4; i++) model_shift(int'(lines[i]));
    end
    chk("t4_drop_count", drop_cnt - d0, 2);
    check_field("t4");

    // 5: game write locked out until the sequence completes
    ln = WIDTH'($urandom);
    val = $urandom_range(0, 8191);
    c0 = cyc_n;
    spi_push(ln, dr);
    repeat (5) tick();
    game_access(1'b1, 5, val, acyc);
    chk("t5_ack_cycle", acyc, c0 + 2 * ROWS + 2);
    model_shift(int'(ln));
    fld[5] = val;
    game_access(1'b0, 5, 0, acyc);
    chk("t5_rvalid", game_rvalid, 1'b1);
    chk("t5_rdata", game_rdata, val);
    check_field("t5");

    // 6: start aborts a running sequence with two lines queued
    spi_push(WIDTH'($urandom), dr);
    spi_push(WIDTH'($urandom), dr);
    repeat (20) tick();
    if (fld[0] != 0) exp_ovf++;
    game_req = 1'b1; game_we = 1'b0; game_row = AW'(3);
    w0 = wr_cnt;
    start = 1'b1; spi_write = 1'b1; spi_line = WIDTH'($urandom);
    tick();
    start = 1'b0; spi_write = 1'b0;
    tick();
    chk("t6_busy_after_start", busy_s, 1'b0);
    chk("t6_game_ack", ack_s, 1'b1);
    game_req = 1'b0;
    repeat (45) tick();
    chk("t6_no_writes", wr_cnt - w0, 0);
    chk("t6_still_idle", busy_s, 1'b0);
    chk("t6_ovf", ovf_cnt, exp_ovf);

    // 7: reload a random field, random lines with random display traffic
    for (int i = 0; i < ROWS; i++) begin
      val = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 8191);
      game_access(1'b1, i, val, acyc);
      fld[i] = val;
    end
    for (int k = 0; k < 4; k++) begin
      ln = WIDTH'($urandom);
      spi_push(ln, dr);
      wait_idle(1'b1, lat);
      model_shift(int'(ln));
      check_field("t7");
    end

    // 8: reset in the middle of a sequence clears everything
    if (fld[0] != 0) exp_ovf++;
    spi_push(WIDTH'($urandom), dr);
    repeat (10) tick();
    nRst = 1'b0;
    @(posedge clk);
    #1;
    chk("t8_busy", busy, 1'b0);
    chk("t8_mem_en", bus.mem_en, 1'b0);
    chk("t8_disp_valid", disp_valid, 1'b0);
    chk("t8_game_rvalid", game_rvalid, 1'b0);
    nRst = 1'b1;
    disp_prev = 1'b0;
    rd_prev = 1'b0;
    repeat (50) tick();
    chk("t8_idle_after", busy_s, 1'b0);
    chk("t8_ovf", ovf_cnt, exp_ovf);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/p18_field_arbiter.md
Name: p18_field_arbiter

Overview:
Owns the single-port playfield row memory and shares it between three requesters: display scanner reads, SPI-loaded garbage-line insertion, and game-logic read/write. SPI line writes are buffered in a small FIFO. Each buffered line runs a multi-cycle shift-up-and-insert sequence that moves every row up by one and writes the new line into the bottom row. The block sits between the SPI word controller (write_line/line outputs), the game core and the VGA row fetcher.

Parameters:
ROWS, 20, playfield rows; row 0 = top, row ROWS-1 = bottom
WIDTH, 13, bits per row (matches the SPI line width)
AW, 5, row address width; must satisfy 2^AW >= ROWS
DEPTH, 4, pending-line FIFO entries (power of 2)

Ports:
clk  in  1  system clock
nRst  in  1  synchronous active-low reset
start  in  1  new game: flush FIFO, abort any shift sequence
spi_write  in  1  push spi_line into FIFO (one-cycle pulse)
spi_line  in  WIDTH  line to insert
line_dropped  out  1  one-cycle pulse: spi_write arrived while FIFO full
disp_req  in  1  display read request
disp_row  in  AW  display row address
disp_valid  out  1  display read data valid (1 cycle after grant)
disp_data  out  WIDTH  display read data
game_req  in  1  game access request
game_we  in  1  1 = write, 0 = read
game_row  in  AW  game row address
game_wdata  in  WIDTH  game write data
game_ack  out  1  game request granted this cycle
game_rvalid  out  1  game read data valid (1 cycle after read ack)
game_rdata  out  WIDTH  game read data
field_overflow  out  1  one-cycle pulse: row 0 was non-zero when discarded by a shift
busy  out  1  shift sequence active or FIFO non-empty
mem_en, mem_we  out  1 each  memory enable / write enable
mem_addr  out  AW  memory address
mem_wdata  out  WIDTH  memory write data
mem_rdata  in  WIDTH  memory read data, valid the cycle after the mem_en read

Behaviour:
- Reset (nRst=0 at clk edge): FIFO empty; engine IDLE; all outputs 0 (mem_en, mem_we, disp_valid, game_ack, game_rvalid, line_dropped, field_overflow, busy).
- Per-cycle memory priority: display > shift engine > game. At most one memory op per cycle.
- Display: disp_req is always granted in its cycle; mem_addr=disp_row, read. disp_valid=1 next cycle with disp_data=mem_rdata.
- Game:
  - game_ack only when disp_req=0 and the engine is IDLE with the FIFO empty. The game is locked out for the whole shift sequence.
  - Write takes effect in the ack cycle.
  - Read: game_rvalid and game_rdata follow one cycle after the ack.
  - Requester holds game_req until acked.
- FIFO:
  - spi_write pushes when not full; when full, the line is dropped and line_dropped pulses.
  - Push and pop in the same cycle are legal at any occupancy, including full.
- Engine states:
  - IDLE: if FIFO non-empty -> CHK.
  - CHK: read row 0, r=1 -> RD.
  - RD: read row r -> WR. On the first RD, if mem_rdata (row 0) != 0, pulse field_overflow.
  - WR: write row r-1 with the captured data; r==ROWS-1 -> INS, else r++ -> RD.
  - INS: write FIFO head to row ROWS-1, pop -> IDLE.
- Stalls: any engine cycle coinciding with disp_req stalls; state and r are held and the op is retried.
  - mem_rdata from the preceding engine read is captured into a hold register whenever the following cycle is stalled.
  - WR uses the hold register if a capture occurred, otherwise live mem_rdata.
  - Overflow check uses the same rule.
- Unstalled sequence length: 2*ROWS cycles (40 at default).
- start=1: FIFO flushed and engine -> IDLE at that edge. A partially shifted field is left as-is. spi_write in the same cycle is discarded. Display service is unaffected.
- busy = engine not IDLE or FIFO non-empty.

Test Plan:
1. Reset, then preload rows 0..19 = row index via game writes; spi_write line 0x1ABC -> after 40 cycles rows 0..18 = 1..19, row 19 = 0x1ABC, field_overflow=0, busy returns 0.
2. Row 0 = 0x0001 before spi_write -> field_overflow pulses exactly once, on the cycle after the CHK read.
3. disp_req held high 10 cycles mid-shift (including a WR cycle) -> each read returns disp_valid next cycle; final field identical to case 1; completion delayed by 10 cycles.
4. Six spi_write pulses back-to-back -> four accepted, line_dropped pulses on writes 5 and 6; four sequences run; bottom 4 rows hold lines 1..4 in order (line 4 in row 19).
5. game_req write during a shift -> no game_ack until busy=0; then acked in one cycle; a subsequent read returns the written value with game_rvalid.
6. start asserted mid-sequence with 2 lines queued -> next cycle busy=0, no further mem writes, game_ack granted on the next pending request.
